// File: rtl/ir_pkg.sv
// Shared IR link definitions: FSM states and pulse-distance timing units used by both
// the wand transmitter and the game-side receiver decoder.
package ir_pkg;

  localparam int unsigned IR_CODE_W        = 16;
  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned ZERO_SPACE_UNITS = 1;
  localparam int unsigned ONE_SPACE_UNITS  = 3;
  localparam int unsigned STOP_UNITS       = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } ir_state_e;

  function automatic logic is_mark(input ir_state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier for the IR LED: restarts high at each mark entry, toggles every
// CARRIER_HALF cycles while enabled, and sits at 0 otherwise.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic restart,
  output logic carrier
);

  localparam int unsigned HALF_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CARRIER_HALF - 1);

  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              carrier_q, carrier_d;

  always_comb begin
    half_cnt_d = '0;
    carrier_d  = 1'b0;
    if (restart) begin
      carrier_d = 1'b1;
    end else if (enable) begin
      if (half_cnt_q == HALF_LAST) begin
        half_cnt_d = '0;
        carrier_d  = ~carrier_q;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
        carrier_d  = carrier_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      half_cnt_q <= '0;
      carrier_q  <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      carrier_q  <= carrier_d;
    end
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/ir_transmitter.sv
// Wand-side IR frame transmitter: leader, MSB-first pulse-distance data bits, stop mark, gap.
// Define IR_TX_PARITY_EN to append an even-parity bit after data bit 0.
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned UNIT_CYCLES  = 28100,
  parameter int unsigned GAP_UNITS    = 72
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [IR_CODE_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 ir_out,
  output logic                 ir_envelope,
  output logic                 busy
);

`ifdef IR_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = IR_CODE_W + 1;
`else
  localparam int unsigned FRAME_BITS = IR_CODE_W;
`endif

  localparam int unsigned CNT_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned MAX_UNITS = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int unsigned UNITS_W   = $clog2(MAX_UNITS + 1);

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [4:0]       LAST_BIT  = 5'(FRAME_BITS - 1);

  ir_state_e               state_q, state_d;
  logic [CNT_W-1:0]        unit_cnt_q, unit_cnt_d;
  logic [UNITS_W-1:0]      units_left_q, units_left_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    envelope_q, envelope_d;

  logic accept;
  logic unit_last;
  logic state_done;
  logic state_entry;
  logic carrier;
  logic carrier_restart;
  logic carrier_enable;

  assign accept      = tx_valid && (state_q == StIdle);
  assign unit_last   = (unit_cnt_q == UNIT_LAST);
  assign state_done  = unit_last && (units_left_q == UNITS_W'(1));
  // Every transition changes state, so a state difference marks an entry.
  assign state_entry = (state_d != state_q);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (tx_valid)   state_d = StLeadMark;
      StLeadMark:  if (state_done) state_d = StLeadSpace;
      StLeadSpace: if (state_done) state_d = StBitMark;
      StBitMark:   if (state_done) state_d = StBitSpace;
      StBitSpace: begin
        if (state_done) state_d = (bit_cnt_q == LAST_BIT) ? StStopMark : StBitMark;
      end
      StStopMark:  if (state_done) state_d = StGap;
      StGap:       if (state_done) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs; the LED drive is built only from flops so inputs never reach it directly.
  always_comb begin
    tx_ready    = (state_q == StIdle);
    busy        = (state_q != StIdle);
    envelope_d  = is_mark(state_d);
    ir_envelope = envelope_q;
    ir_out      = envelope_q & carrier;
  end

  // Unit timing and data shifting
  always_comb begin
    units_left_d = units_left_q;
    if (state_entry) begin
      unique case (state_d)
        StLeadMark:  units_left_d = UNITS_W'(LEAD_MARK_UNITS);
        StLeadSpace: units_left_d = UNITS_W'(LEAD_SPACE_UNITS);
        StBitMark:   units_left_d = UNITS_W'(STOP_UNITS);
        StBitSpace:  units_left_d = shift_q[FRAME_BITS-1] ? UNITS_W'(ONE_SPACE_UNITS)
                                                          : UNITS_W'(ZERO_SPACE_UNITS);
        StStopMark:  units_left_d = UNITS_W'(STOP_UNITS);
        StGap:       units_left_d = UNITS_W'(GAP_UNITS);
        default:     units_left_d = '0;
      endcase
    end else if (unit_last && (state_q != StIdle)) begin
      units_left_d = units_left_q - 1'b1;
    end
  end

  always_comb begin
    if (state_entry || (state_q == StIdle) || unit_last) begin
      unit_cnt_d = '0;
    end else begin
      unit_cnt_d = unit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
`ifdef IR_TX_PARITY_EN
      shift_d = {tx_data, ^tx_data};
`else
      shift_d = tx_data;
`endif
      bit_cnt_d = '0;
    end else if ((state_q == StBitSpace) && state_done) begin
      shift_d   = shift_q << 1;
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      unit_cnt_q   <= '0;
      units_left_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      envelope_q   <= 1'b0;
    end else begin
      unit_cnt_q   <= unit_cnt_d;
      units_left_q <= units_left_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      envelope_q   <= envelope_d;
    end
  end

  assign carrier_enable  = is_mark(state_d);
  assign carrier_restart = state_entry && is_mark(state_d);

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (carrier_enable),
    .restart (carrier_restart),
    .carrier (carrier)
  );

endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

Wand-side IR frame transmitter: the emitting end of the link whose 16-bit codes arrive at the game's `ir_in_p1`/`ir_in_p2` receiver inputs. It accepts a 16-bit spell/player code through a valid/ready handshake and serialises it as a pulse-distance frame: leader, 16 data bits MSB-first and a stop mark. Each mark is modulated onto a square-wave carrier that drives the IR LED. One instance sits in each wand controller; a guard gap follows every frame before the next code is accepted.

## Interface
- `CARRIER_HALF`, default 658: clock cycles per carrier half-period (50 MHz / 38 kHz / 2).
- `UNIT_CYCLES`, default 28100: clock cycles per timing unit (562 µs at 50 MHz); must be ≥ 2·`CARRIER_HALF`.
- `GAP_UNITS`, default 72: space units after the stop mark before `tx_ready` returns.
- `clock` in 1: system clock. One clock; reset is synchronous and active-low.
- `resetn` in 1: synchronous, active-low reset.
- `tx_data` in 16: code to send; sampled only on the accept cycle.
- `tx_valid` in 1: a code is offered.
- `tx_ready` out 1: high only in IDLE; accept = `tx_valid & tx_ready`.
- `ir_out` out 1: modulated LED drive, equal to `ir_envelope & carrier`.
- `ir_envelope` out 1: unmodulated mark (1) / space (0) envelope.
- `busy` out 1: equal to `~tx_ready`.

## Operation
- States: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8), BIT_MARK (1), BIT_SPACE (1 unit for a 0, 3 units for a 1), STOP_MARK (1), GAP (`GAP_UNITS`), then back to IDLE.
- On accept, `tx_data` is latched into a shift register. Bits are sent MSB first. A 5-bit bit counter runs from 0 to 15; after the space for bit 15 the FSM goes to STOP_MARK.
- Unit counter counts 0..`UNIT_CYCLES`-1. A unit-count register holds the remaining units of the current state. Both counters reload on every state entry.
- `ir_envelope` is 1 in the *_MARK states and 0 otherwise.
- Carrier counter: restarts at every mark entry with carrier = 1, then toggles every `CARRIER_HALF` cycles. It is held at 0 during spaces.
- Frame length: 0x0000 gives 24 + 16·2 + 1 = 57 units; 0xFFFF gives 24 + 16·4 + 1 = 89 units. GAP is added to both.
- `tx_valid` asserted while busy is ignored; no queueing. `tx_data` changes after accept have no effect.
- Reset mid-frame: the frame is aborted at that clock edge. The FSM goes to IDLE, all counters clear and `ir_out`/`ir_envelope` drop to 0. No partial stop mark or gap is sent.
- Reset values: `ir_out` = 0, `ir_envelope` = 0, `busy` = 0, `tx_ready` = 1 (IDLE).

## Timing
- Accept at edge N: at edge N+1 the state is LEAD_MARK, and `ir_envelope` and `ir_out` are 1 in cycle N+1.
- `ir_envelope` and `ir_out` are registered, with no combinational path from inputs.
- Each state lasts exactly units × `UNIT_CYCLES` cycles.
- The last GAP cycle is followed by IDLE, with `tx_ready` = 1 in the next cycle. If `tx_valid` is held, back-to-back frames have exactly one IDLE cycle between GAP and the next LEAD_MARK.
- Each mark lasts exactly (units × `UNIT_CYCLES`) cycles. Carrier edges inside a mark fall at offsets k·`CARRIER_HALF` from mark start.

## Configuration
- `IR_TX_PARITY_EN` defined: a 17th bit is sent after bit 0. It is the even-parity bit (XOR of the 16 data bits) and uses the same 0/1 space encoding. The bit counter runs 0..16.
- Not defined: exactly 16 data bits are sent, and no parity logic is synthesised.

## Structure
- Package `ir_pkg`:
  - the state enum;
  - unit constants `LEAD_MARK_UNITS`=16, `LEAD_SPACE_UNITS`=8, `ZERO_SPACE_UNITS`=1, `ONE_SPACE_UNITS`=3, `STOP_UNITS`=1;
  - `IR_CODE_W`=16.
- These constants are shared with the receiver decoder.
- Sub-module `ir_carrier_gen`:
  - ports: `clock`, `resetn`, `enable`, `restart`, `carrier`;
  - contains the half-period counter and toggle flop;
  - instantiated once.

## Test plan
Bench parameters: `CARRIER_HALF`=2, `UNIT_CYCLES`=8, `GAP_UNITS`=4.

1. Send 0x0000 (parity off) → `ir_envelope` high 128 cycles, low 64 cycles, then 16× (high 8, low 8), stop high 8, low 32. `tx_ready` returns 1 exactly 488 cycles after the first LEAD_MARK cycle.
2. Send 0xA5C3 → decoded space lengths are 24 or 8 cycles per bit, MSB first, giving bit pattern 1010_0101_1100_0011. `ir_out` toggles every 2 cycles inside marks and is 0 in spaces.
3. Hold `tx_valid`=1 with 0x0001 then 0x8000 → two frames with exactly one IDLE cycle between them. The second frame's data is unaffected by `tx_data` changes during the first.
4. Assert `resetn`=0 for 1 cycle in bit 7's mark → the next cycle shows `ir_out`=0, `ir_envelope`=0 and `tx_ready`=1. A new accept then produces a clean full frame.
5. `tx_valid` pulses while busy → ignored, and the frame count stays at 1.
6. With `IR_TX_PARITY_EN`, send 0x0007 (three ones) → a 17th bit with 24-cycle space (parity 1) is sent before the stop mark. Send 0x0003 → parity space is 8 cycles.
